// File: rtl/a1csa_mp_sequencer.sv
// Multi-precision add sequencer: one 8-bit limb per cycle through a single a1csa8bits.
// Optional signed-overflow output enabled by defining A1CSA_SEQ_OVF_EN.

// 8-bit add-one carry-select adder: low nibble ripples, high nibble picks a+b or a+b+1.
// Latency: combinational.
// Backpressure: none.
module a1csa8bits (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] s,
  output logic       cout
);
  logic [4:0] lo;
  logic [4:0] hi0;
  logic [4:0] hi1;

  always_comb begin
    lo  = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'b0000, cin};
    hi0 = {1'b0, a[7:4]} + {1'b0, b[7:4]};
    hi1 = hi0 + 5'd1;
    {cout, s} = lo[4] ? {hi1, lo[3:0]} : {hi0, lo[3:0]};
  end
endmodule

// Wide add sequenced over WORDS limbs with the carry held in a register between limbs.
// Latency: out_valid rises WORDS cycles after accept; minimum issue period WORDS+2.
// Backpressure: result held in DONE until out_ready; in_ready low outside IDLE.
module a1csa_mp_sequencer #(
  parameter int WORDS = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               cin,
  input  logic [8*WORDS-1:0] a,
  input  logic [8*WORDS-1:0] b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [8*WORDS-1:0] s,
  output logic               cout
`ifdef A1CSA_SEQ_OVF_EN
  , output logic             ovf
`endif
);
  localparam int W  = 8 * WORDS;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  s_q, s_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          carry_q, carry_d;
  logic          cout_q, cout_d;
`ifdef A1CSA_SEQ_OVF_EN
  logic          ovf_q, ovf_d;
`endif

  logic [IW+2:0] sh;
  logic [7:0]    limb_a;
  logic [7:0]    limb_b;
  logic [7:0]    add_s;
  logic          add_co;

  assign sh     = {idx_q, 3'b000};
  assign limb_a = 8'(a_q >> sh);
  assign limb_b = 8'(b_q >> sh);

  a1csa8bits u_add (
    .a    (limb_a),
    .b    (limb_b),
    .cin  (carry_q),
    .s    (add_s),
    .cout (add_co)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
`ifdef A1CSA_SEQ_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          s_d     = '0;
          idx_d   = '0;
`ifdef A1CSA_SEQ_OVF_EN
          ovf_d   = 1'b0;
`endif
          state_d = RUN;
        end
      end
      RUN: begin
        // Splice this limb's sum into its byte lane, leaving the others untouched.
        s_d     = (s_q & ~(W'(8'hFF) << sh)) | (W'(add_s) << sh);
        carry_d = add_co;
        if (idx_q == LAST) begin
          cout_d  = add_co;
`ifdef A1CSA_SEQ_OVF_EN
          ovf_d   = (a_q[W-1] == b_q[W-1]) & (add_s[7] != a_q[W-1]);
`endif
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
`ifdef A1CSA_SEQ_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
`ifdef A1CSA_SEQ_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign s         = s_q;
  assign cout      = cout_q;
`ifdef A1CSA_SEQ_OVF_EN
  assign ovf       = ovf_q;
`endif
endmodule

// File: doc/a1csa_mp_sequencer.md
# a1csa_mp_sequencer

Multi-precision add sequencer that processes wide operands one 8-bit limb per cycle through a single `a1csa8bits` instance. Each limb's `cout` is registered and fed back as the next limb's `cin`. The block sits directly upstream of the 8-bit add-one carry-select adder and owns its operand slicing, carry chaining and result assembly. Operands and results move over valid/ready handshakes, so one narrow adder can serve wide datapaths.

## Interface
- `WORDS`, 4: number of 8-bit limbs; operand width is 8*WORDS; legal range 1..16.
- `clk` input 1: sole clock; all state updates on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: operand set presented.
- `in_ready` output 1: block can accept operands.
- `cin` input 1: carry into limb 0; sampled at accept.
- `a` input 8*WORDS: operand A; sampled at accept.
- `b` input 8*WORDS: operand B; sampled at accept.
- `out_valid` output 1: result held stable.
- `out_ready` input 1: consumer takes the result.
- `s` output 8*WORDS: sum.
- `cout` output 1: carry out of the top limb.
- `ovf` output 1: signed overflow; present only with `A1CSA_SEQ_OVF_EN`.

## Operation
- FSM states: IDLE, RUN, DONE. Reset goes to IDLE with `s`=0, `cout`=0, `out_valid`=0, `ovf`=0, limb index=0, and the carry register=0. `in_ready`=1 after reset, since it equals (state==IDLE).
- Accept: the edge where `in_valid`&`in_ready`.
  - Register `a`, `b` and `cin` into the carry register.
  - Clear `s`, clear the index, and go to RUN.
- RUN, at index i:
  - Drive the adder with `a[8i+7:8i]`, `b[8i+7:8i]` and the carry register.
  - At the edge, write the adder sum into `s[8i+7:8i]`, load the adder cout into the carry register, and increment i.
  - When i==WORDS-1, instead go to DONE and load `cout` from the adder cout.
- DONE: `out_valid`=1, with `s`/`cout`/`ovf` held stable. The edge where `out_ready`=1 returns the FSM to IDLE and clears `out_valid`. `s` keeps its value until the next accept.
- Width rules: unsigned modular sum, so `s` = (a+b+cin) mod 2^(8*WORDS) and `cout` = bit 8*WORDS of the full sum.
- `in_valid` during RUN/DONE is ignored; the source must hold its operands.
- `out_ready` outside DONE is ignored.
- `rst` mid-RUN or in DONE aborts the operation. The result is discarded, state returns to IDLE, and all outputs take their reset values on that edge.
- WORDS=1: RUN lasts one cycle, then DONE.

## Timing
- Latency: accept at edge E0 leads to `out_valid` high after edge E(WORDS). WORDS=4 gives 4 cycles.
- Minimum issue period is WORDS+2 cycles:
  - WORDS cycles in RUN.
  - 1 cycle in DONE, with `out_ready` already high.
  - 1 cycle in IDLE.
- Combinational path per cycle: operand mux, then the 8-bit adder, then the limb register. There is no path from input to output.
- `in_ready` and `out_valid` are registered-state decodes and never depend combinationally on `in_valid`/`out_ready`.

## Configuration
- `A1CSA_SEQ_OVF_EN` defined:
  - The `ovf` port exists.
  - At the final RUN edge, `ovf` is registered as (a[MSB]==b[MSB]) & (sum[MSB]!=a[MSB]), where MSB is 8*WORDS-1.
  - `ovf` is valid with `out_valid`, cleared at reset and accept.
- `A1CSA_SEQ_OVF_EN` undefined: no `ovf` port and no associated logic. All other behaviour is identical.

## Test plan
- Reset, then idle: `in_ready`=1, `out_valid`=0, `s`=0, `cout`=0. Assert `rst` for 1 cycle mid-RUN: the next cycle is IDLE with outputs zero.
- WORDS=4, a=0xFFFFFFFF, b=0x00000001, cin=0: `s`=0x00000000, `cout`=1, `out_valid` rises 4 cycles after accept. Checks the full carry ripple across limbs.
- WORDS=4, a=0x12345678, b=0x0F0F0F0F, cin=1: `s`=0x21436588, `cout`=0.
- Backpressure: hold `out_ready`=0 for 10 cycles in DONE. `s`/`cout` stay stable, `in_ready`=0, and a toggling `in_valid` is ignored. Then `out_ready`=1: IDLE the next cycle, and the next accept occurs WORDS+2 cycles after the previous one.
- With `A1CSA_SEQ_OVF_EN`, WORDS=4: a=0x7FFFFFFF, b=1 gives `ovf`=1 and `cout`=0. a=0x80000000, b=0x80000000 gives `ovf`=1, `cout`=1, `s`=0.
- WORDS=1, a=0xFF, b=0xFF, cin=1: `s`=0xFF, `cout`=1, latency 1 cycle.
